// File: rtl/vm_pkg.sv
// vm_pkg: shared vending-machine types and coin constants.
// Provides coin unit values (nickel units), the dispenser state enum,
// the coin-select enum shared with the drink controller, and a helper
// that maps a coin selection to its value in nickel units.
package vm_pkg;

    localparam int QTR_UNITS    = 5;
    localparam int DIME_UNITS   = 2;
    localparam int NICKEL_UNITS = 1;

    typedef enum logic [1:0] {IDLE, DISP, GAPW, FIN} state_e;

    typedef enum logic [1:0] {NONE, NICKEL, DIME, QUARTER} coin_e;

    function automatic logic [2:0] coin_units(input coin_e c);
        return c == QUARTER ? 3'(QTR_UNITS) :
               c == DIME    ? 3'(DIME_UNITS) :
               c == NICKEL  ? 3'(NICKEL_UNITS) : 3'd0;
    endfunction

endpackage

// File: rtl/change_dispenser_gap_timer.sv
// gap_timer: loadable 4-bit down-counter with zero flag.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset (count -> 0)
//   load_i     - load load_val_i into the counter (has priority)
//   load_val_i - value to load
//   dec_i      - decrement by one, saturating at zero
//   zero_o     - counter is zero
module gap_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= 4'd0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i && cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
    end

    assign zero_o = cnt_q == 4'd0;

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: emits change as greedy quarter/dime/nickel hopper pulses.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-high reset
//   start      - begin a dispense (accepted only in IDLE)
//   amount     - change owed in nickel units, captured with start
//   hopper_rdy - hopper accepts a pulse this cycle
//   q, d, n    - one-cycle quarter/dime/nickel pulses (Mealy, one-hot or zero)
//   busy       - dispense in progress (DISP, GAPW, FIN)
//   done       - one-cycle completion pulse (FIN)
//   coin_cnt   - coins emitted for the current/last request
module change_dispenser
    import vm_pkg::*;
#(
    parameter int          AMT_W = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             hopper_rdy,
    output logic             q,
    output logic             d,
    output logic             n,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] coin_cnt
);

    // Timer is loaded with GAP-1 on the pulse edge so GAPW lasts exactly GAP cycles.
    localparam logic [3:0] GAP_LD = GAP > 0 ? 4'(GAP - 1) : 4'd0;

    state_e           state_q;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] remaining_d;
    logic [AMT_W-1:0] coin_cnt_q;
    coin_e            coin_sel;
    logic             gap_zero;

    always_comb begin
        coin_sel = (state_q != DISP || !hopper_rdy) ? NONE :
                   remaining_q >= AMT_W'(QTR_UNITS)  ? QUARTER :
                   remaining_q >= AMT_W'(DIME_UNITS) ? DIME :
                   remaining_q != '0                 ? NICKEL : NONE;
        remaining_d = remaining_q - AMT_W'(coin_units(coin_sel));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            coin_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    remaining_q <= amount;
                    coin_cnt_q  <= '0;
                    state_q     <= amount == '0 ? FIN : DISP;
                end
                DISP: if (coin_sel != NONE) begin
                    remaining_q <= remaining_d;
                    coin_cnt_q  <= coin_cnt_q + AMT_W'(1);
                    state_q     <= GAP > 0 ? GAPW : remaining_d != '0 ? DISP : FIN;
                end
                GAPW: if (gap_zero)
                    state_q <= remaining_q != '0 ? DISP : FIN;
                FIN: state_q <= IDLE;
            endcase
        end
    end

    gap_timer u_gap (
        .clk        (clk),
        .rst        (reset),
        .load_i     (coin_sel != NONE),
        .load_val_i (GAP_LD),
        .dec_i      (state_q == GAPW),
        .zero_o     (gap_zero)
    );

    assign q        = coin_sel == QUARTER;
    assign d        = coin_sel == DIME;
    assign n        = coin_sel == NICKEL;
    assign busy     = state_q != IDLE;
    assign done     = state_q == FIN;
    assign coin_cnt = coin_cnt_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-return end of the drink vending machine: the drink machine accepts nickel/dime/quarter pulses, and this block emits them.
- On a start request it takes a change amount and drives the coin hopper with one-cycle n/d/q pulses, largest coin first, until the amount is exhausted.
- Sits between the drink controller (change owed) and the physical hopper (accepts a pulse only when ready).

Parameters:
- AMT_W, 8, width of the change amount in nickel units (1 unit = 5 cents); max 255 units = 1275 cents.
- GAP, 1, idle cycles forced after each coin pulse (hopper recovery); legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request to dispense change; sampled only in IDLE.
- amount  input  AMT_W  change owed in nickel units; captured with start.
- hopper_rdy  input  1  hopper can accept a coin pulse this cycle.
- q  output  1  one-cycle quarter pulse (5 units).
- d  output  1  one-cycle dime pulse (2 units).
- n  output  1  one-cycle nickel pulse (1 unit).
- busy  output  1  dispense in progress.
- done  output  1  one-cycle pulse: dispense complete.
- coin_cnt  output  AMT_W  number of coins emitted for the current/last request.

Behaviour:
- Reset values: q=d=n=0, busy=0, done=0, coin_cnt=0, state IDLE, remaining=0, gap counter=0.
- States: IDLE, DISP, GAPW, FIN.
- IDLE:
  - When start=1 at an edge: capture amount into remaining, clear coin_cnt, go to DISP (or FIN if amount=0).
  - When start=0: stay.
- DISP:
  - If hopper_rdy=1, pulse exactly one output for that cycle, chosen greedily:
    - q if remaining>=5;
    - else d if remaining>=2;
    - else n.
  - On that edge: subtract the coin value from remaining and increment coin_cnt.
  - Next state: GAPW if GAP>0; else DISP if new remaining>0; else FIN.
  - If hopper_rdy=0: no pulse, no change; wait indefinitely.
- GAPW: count GAP cycles with all coin outputs low, then go to DISP if remaining>0, else FIN.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in DISP, GAPW and FIN; 0 in IDLE.
- Coin outputs are combinational from state, remaining and hopper_rdy (Mealy). At most one of q/d/n is high in any cycle, and never high outside DISP.
- start while busy: ignored; not queued; amount not re-sampled.
- start in the FIN cycle: ignored. The earliest accepted start is the first IDLE cycle.
- Arithmetic: remaining is unsigned AMT_W bits and never underflows, because greedy selection guarantees coin value <= remaining.
- coin_cnt holds its final value in IDLE until the next accepted start.
- Reset mid-dispense: outputs drop in the same cycle (asynchronous); the partial dispense is abandoned with no done pulse.

Decomposition:
- Shared package vm_pkg:
  - coin unit constants QTR_UNITS=5, DIME_UNITS=2, NICKEL_UNITS=1;
  - state enum typedef (IDLE, DISP, GAPW, FIN);
  - coin-select typedef (NONE, NICKEL, DIME, QUARTER), also used by the drink controller.
- One sub-module, gap_timer: loadable down-counter of 4 bits with a zero flag, async active-high reset; instantiated for GAPW.

Test Plan:
- GAP=1, hopper_rdy=1, start with amount=3 in cycle 0 -> d in cycle 1, n in cycle 3, done in cycle 5, coin_cnt=2, busy high cycles 1-5.
- amount=8 (40 cents) -> pulse order q, d, n, each separated by one idle cycle; coin_cnt=3; remaining reaches 0.
- amount=0 -> no coin pulses; busy and done high in cycle 1 only; coin_cnt=0.
- amount=5 with hopper_rdy held low cycles 1-4 and raised in cycle 5 -> single q in cycle 5, done in cycle 7.
- amount=255 -> 51 q pulses and nothing else; coin_cnt=51; a start pulse mid-run is ignored and not replayed.
- Reset asserted between coin pulses of amount=8 -> outputs 0 at once, no done, IDLE; a following start with amount=1 -> single n.
